// File: rtl/raw_frame_sequencer_pkg.sv
// =============================================================================
// xike_seq_pkg : shared types and constants for raw_frame_sequencer
// Revision     : 1.0
// =============================================================================
`default_nettype none

package xike_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIGN  = 2'd1,
    HEADER = 2'd2,
    DATA   = 2'd3
  } seq_state_e;

  localparam logic [15:0] c_SYNC_WORD = 16'hA55A;
  localparam int c_SAMPLE_W  = 16;
  localparam int c_N_STREAMS = 5;
  localparam int c_BEAT_W    = c_SAMPLE_W * c_N_STREAMS;

  localparam int c_HDR_SYNC_LSB = 64;
  localparam int c_HDR_FC_LSB   = 32;
  localparam int c_HDR_LO_LSB   = 0;

  function automatic logic [c_BEAT_W-1:0] make_header(
    input logic [15:0] sync,
    input logic [31:0] fc,
    input logic [31:0] lo
  );
    logic [c_BEAT_W-1:0] hdr;
    hdr = '0;
    hdr[c_HDR_SYNC_LSB +: 16] = sync;
    hdr[c_HDR_FC_LSB   +: 32] = fc;
    hdr[c_HDR_LO_LSB   +: 32] = lo;
    return hdr;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_reg_80.sv
// =============================================================================
// axis_skid_reg_80 : 2-entry AXI4-Stream register slice (80-bit data + tlast)
// Revision         : 1.0
// =============================================================================
`default_nettype none

module axis_skid_reg_80
  import xike_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [c_BEAT_W-1:0] i_data,
  input  logic                i_last,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [c_BEAT_W-1:0] o_data,
  output logic                o_last
);

  logic                r_out_valid;
  logic [c_BEAT_W-1:0] r_out_data;
  logic                r_out_last;
  logic                r_skid_valid;
  logic [c_BEAT_W-1:0] r_skid_data;
  logic                r_skid_last;
  logic                w_push;

  // Ready depends only on the skid entry, so it never combinationally follows i_ready.
  assign o_ready = !r_skid_valid;
  assign w_push  = i_valid && o_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
    end else if (!r_out_valid || i_ready) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_last   <= r_skid_last;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_push;
        if (w_push) begin
          r_out_data <= i_data;
          r_out_last <= i_last;
        end
      end
    end else if (w_push) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= i_data;
      r_skid_last  <= i_last;
    end
  end

  assign o_valid = r_out_valid;
  assign o_data  = r_out_data;
  assign o_last  = r_out_last;

endmodule

`default_nettype wire

// File: rtl/raw_frame_sequencer.sv
// =============================================================================
// raw_frame_sequencer : frame-aligned acquisition controller with header/tlast
// Optional macro TIMESTAMP_EN puts a cycle-count timestamp in the header.
// Revision            : 1.0
// =============================================================================
`default_nettype none

module raw_frame_sequencer
  import xike_seq_pkg::*;
#(
  parameter int          BEATS_PER_FRAME = 32,
  parameter logic [15:0] SYNC_WORD       = c_SYNC_WORD,
  parameter int          FRAME_CNT_W     = 32
) (
  input  logic                   bus_clk,
  input  logic                   xike_rst_n,
  input  logic                   acq_start,
  input  logic                   acq_stop,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [c_BEAT_W-1:0]    s_tdata,
  input  logic                   s_tfirst,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [c_BEAT_W-1:0]    m_tdata,
  output logic                   m_tlast,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [15:0]            sync_err_count,
  output logic                   busy
);

  localparam int                 c_IDX_W    = $clog2(BEATS_PER_FRAME);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BEATS_PER_FRAME - 1);

  seq_state_e           r_state;
  logic [FRAME_CNT_W-1:0] r_frame_count;
  logic [15:0]          r_sync_err;
  logic [c_IDX_W-1:0]   r_beat_idx;
  logic                 r_stop_pending;

  logic                 w_space;
  logic                 w_push;
  logic [c_BEAT_W-1:0]  w_push_data;
  logic                 w_push_last;
  logic                 w_tready;
  logic                 w_misalign;
  logic [31:0]          w_hdr_lo;
  logic [c_BEAT_W-1:0]  w_header;

`ifdef TIMESTAMP_EN
  logic [31:0] r_cycle_cnt;

  always_ff @(posedge bus_clk or negedge xike_rst_n) begin
    if (!xike_rst_n) r_cycle_cnt <= '0;
    else             r_cycle_cnt <= r_cycle_cnt + 32'd1;
  end

  assign w_hdr_lo = r_cycle_cnt;
`else
  assign w_hdr_lo = {16'(BEATS_PER_FRAME), 16'h0000};
`endif

  assign w_header   = make_header(SYNC_WORD, 32'(r_frame_count), w_hdr_lo);
  assign w_misalign = s_tvalid && s_tfirst && (r_beat_idx != '0);

  always_comb begin
    w_tready    = 1'b0;
    w_push      = 1'b0;
    w_push_data = '0;
    w_push_last = 1'b0;
    case (r_state)
      IDLE:   w_tready = 1'b1;
      // The channel-0 beat is left on the bus so DATA can take it as beat 0.
      ALIGN:  w_tready = !(s_tvalid && s_tfirst);
      HEADER: begin
        w_push      = w_space;
        w_push_data = w_header;
      end
      DATA: begin
        if (w_misalign) begin
          w_push      = w_space;
          w_push_last = 1'b1;
        end else begin
          w_tready    = w_space;
          w_push      = s_tvalid && w_space;
          w_push_data = s_tdata;
          w_push_last = (r_beat_idx == c_LAST_IDX);
        end
      end
      default: w_tready = 1'b0;
    endcase
  end

  assign s_tready = xike_rst_n && w_tready;

  always_ff @(posedge bus_clk or negedge xike_rst_n) begin
    if (!xike_rst_n) begin
      r_state        <= IDLE;
      r_frame_count  <= '0;
      r_sync_err     <= '0;
      r_beat_idx     <= '0;
      r_stop_pending <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (acq_start && !acq_stop) begin
            r_frame_count  <= '0;
            r_stop_pending <= 1'b0;
            r_state        <= ALIGN;
          end
        end
        ALIGN: begin
          if (acq_stop)                  r_state <= IDLE;
          else if (s_tvalid && s_tfirst) r_state <= HEADER;
        end
        HEADER: begin
          if (acq_stop) r_stop_pending <= 1'b1;
          if (w_space) begin
            r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
            r_beat_idx    <= '0;
            r_state       <= DATA;
          end
        end
        DATA: begin
          if (acq_stop) r_stop_pending <= 1'b1;
          if (w_push) begin
            if (w_misalign) begin
              if (r_sync_err != 16'hFFFF) r_sync_err <= r_sync_err + 16'd1;
              r_state <= HEADER;
            end else if (r_beat_idx == c_LAST_IDX) begin
              r_beat_idx <= '0;
              if (r_stop_pending || acq_stop) begin
                r_stop_pending <= 1'b0;
                r_state        <= IDLE;
              end else begin
                r_state <= HEADER;
              end
            end else begin
              r_beat_idx <= r_beat_idx + c_IDX_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  axis_skid_reg_80 u_skid (
    .clk     (bus_clk),
    .rst_n   (xike_rst_n),
    .i_valid (w_push),
    .o_ready (w_space),
    .i_data  (w_push_data),
    .i_last  (w_push_last),
    .o_valid (m_tvalid),
    .i_ready (m_tready),
    .o_data  (m_tdata),
    .o_last  (m_tlast)
  );

  assign frame_count    = r_frame_count;
  assign sync_err_count = r_sync_err;
  assign busy           = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_raw_frame_sequencer.sv
// =============================================================================
// tb_raw_frame_sequencer : directed + randomized bench with a frame-level model
// Revision               : 1.0
// =============================================================================
`default_nettype none

module tb_raw_frame_sequencer;

  localparam int c_N = 32;

  logic        bus_clk = 1'b0;
  logic        xike_rst_n = 1'b1;
  logic        acq_start = 1'b0;
  logic        acq_stop = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [79:0] s_tdata = '0;
  logic        s_tfirst = 1'b0;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [79:0] m_tdata;
  logic        m_tlast;
  logic [31:0] frame_count;
  logic [15:0] sync_err_count;
  logic        busy;

  raw_frame_sequencer dut (
    .bus_clk        (bus_clk),
    .xike_rst_n     (xike_rst_n),
    .acq_start      (acq_start),
    .acq_stop       (acq_stop),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_tdata        (s_tdata),
    .s_tfirst       (s_tfirst),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tdata        (m_tdata),
    .m_tlast        (m_tlast),
    .frame_count    (frame_count),
    .sync_err_count (sync_err_count),
    .busy           (busy)
  );

  always #5 bus_clk = ~bus_clk;

  int errors = 0;
  int checks = 0;

  logic [79:0] in_data_q[$];
  bit          in_first_q[$];
  logic [79:0] exp_data_q[$];
  bit          exp_last_q[$];

  int          m_fc = 0;
  int          m_err = 0;
  int          popped = 0;
  int          valid_pct = 100;
  int          ready_pct = 100;
  bit          prev_stall = 1'b0;
  logic [79:0] prev_data = '0;
  logic        prev_last = 1'b0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_beat(input bit f);
    in_data_q.push_back({$urandom(), $urandom(), 16'($urandom())});
    in_first_q.push_back(f);
  endtask

  task automatic push_hdr();
    exp_data_q.push_back({16'hA55A, 32'(m_fc), 16'd32, 16'h0000});
    exp_last_q.push_back(1'b0);
    m_fc++;
  endtask

  // Frame-level reference: walks the presented beat stream and lists the output beats.
  task automatic build_model(input bit stop_after_first);
    bit aligned = 1'b0;
    int idx = 0;
    for (int i = 0; i < in_data_q.size(); i++) begin
      if (!aligned) begin
        if (!in_first_q[i]) continue;
        aligned = 1'b1;
        push_hdr();
        idx = 0;
      end else if (in_first_q[i] && idx != 0) begin
        exp_data_q.push_back('0);
        exp_last_q.push_back(1'b1);
        m_err++;
        push_hdr();
        idx = 0;
      end
      exp_data_q.push_back(in_data_q[i]);
      exp_last_q.push_back(idx == c_N - 1);
      idx++;
      if (idx == c_N) begin
        idx = 0;
        if (stop_after_first) break;
        push_hdr();
      end
    end
  endtask

  // One clock cycle: drive at the negedge, sample just after, then advance.
  task automatic cyc();
    if (in_data_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      s_tvalid = 1'b1;
      s_tdata  = in_data_q[0];
      s_tfirst = in_first_q[0];
    end else begin
      s_tvalid = 1'b0;
      s_tdata  = {$urandom(), $urandom(), 16'($urandom())};
      s_tfirst = 1'b0;
    end
    m_tready = ($urandom_range(99) < ready_pct);
    #1;
    if (prev_stall)
      check("stall_hold", {m_tvalid, m_tlast, m_tdata[77:0]}, {1'b1, prev_last, prev_data[77:0]});
    if (m_tvalid && m_tready) begin
      checks++;
      assert (exp_data_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_beat: observed=%h expected=none", m_tdata);
      end
      if (exp_data_q.size() != 0)
        check("out_beat", {m_tlast, m_tdata}, {exp_last_q.pop_front(), exp_data_q.pop_front()});
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (s_tvalid && s_tready) begin
      void'(in_data_q.pop_front());
      void'(in_first_q.pop_front());
      popped++;
    end
    @(posedge bus_clk);
    @(negedge bus_clk);
    acq_start = 1'b0;
    acq_stop  = 1'b0;
  endtask

  task automatic do_reset();
    xike_rst_n = 1'b0;
    acq_start = 1'b0;
    acq_stop  = 1'b0;
    s_tvalid  = 1'b0;
    s_tfirst  = 1'b0;
    m_tready  = 1'b0;
    #1;
    check("rst_m_tvalid", 80'(m_tvalid), 80'd0);
    check("rst_m_tlast", 80'(m_tlast), 80'd0);
    check("rst_m_tdata", m_tdata, 80'd0);
    check("rst_s_tready", 80'(s_tready), 80'd0);
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_counters", 80'({frame_count, sync_err_count}), 80'd0);
    @(negedge bus_clk);
    xike_rst_n = 1'b1;
    in_data_q.delete();
    in_first_q.delete();
    exp_data_q.delete();
    exp_last_q.delete();
    prev_stall = 1'b0;
    m_fc = 0;
    m_err = 0;
    popped = 0;
    valid_pct = 100;
    ready_pct = 100;
  endtask

  task automatic start();
    acq_start = 1'b1;
    cyc();
  endtask

  task automatic run(input int stop_at, input int max_cyc);
    int n = 0;
    bit sent = 1'b0;
    while ((in_data_q.size() > 0 || exp_data_q.size() > 0) && n < max_cyc) begin
      if (stop_at >= 0 && !sent && popped == stop_at) begin
        acq_stop = 1'b1;
        sent = 1'b1;
      end
      cyc();
      n++;
    end
    check("drain_in_budget", 80'(n < max_cyc), 80'd1);
    ready_pct = 100;
    repeat (6) cyc();
  endtask

  task automatic end_checks();
    check("frame_count", 80'(frame_count), 80'(m_fc));
    check("sync_err_count", 80'(sync_err_count), 80'(m_err));
  endtask

  initial begin
    #3;
    do_reset();

    // Aligned start, two frames back to back.
    start();
    for (int i = 0; i < 2 * c_N; i++) push_beat(i % c_N == 0);
    build_model(1'b0);
    run(-1, 2000);
    end_checks();
    check("busy_running", 80'(busy), 80'd1);

    // Junk before channel 0 is discarded.
    do_reset();
    start();
    repeat (5) push_beat(1'b0);
    for (int i = 0; i < c_N; i++) push_beat(i == 0);
    build_model(1'b0);
    run(-1, 2000);
    end_checks();

    // Channel 0 arrives at beat_idx 17.
    do_reset();
    start();
    push_beat(1'b1);
    repeat (16) push_beat(1'b0);
    push_beat(1'b1);
    repeat (31) push_beat(1'b0);
    build_model(1'b0);
    run(-1, 2000);
    end_checks();

    // Random back-pressure and input gaps over three frames.
    do_reset();
    start();
    valid_pct = 70;
    ready_pct = 50;
    for (int i = 0; i < 3 * c_N; i++) push_beat(i % c_N == 0);
    build_model(1'b0);
    run(-1, 5000);
    end_checks();

    // Stop at data beat 10: frame completes, trailing beats are dropped in IDLE.
    do_reset();
    start();
    for (int i = 0; i < c_N; i++) push_beat(i == 0);
    push_beat(1'b1);
    repeat (3) push_beat(1'b0);
    build_model(1'b1);
    run(10, 2000);
    end_checks();
    check("busy_after_stop", 80'(busy), 80'd0);

    // Start and stop together in IDLE: nothing happens.
    do_reset();
    acq_start = 1'b1;
    acq_stop  = 1'b1;
    cyc();
    check("busy_start_stop", 80'(busy), 80'd0);
    repeat (4) push_beat(1'b1);
    run(-1, 200);
    check("busy_start_stop_late", 80'(busy), 80'd0);
    end_checks();

    // Asynchronous reset in the middle of DATA, then a clean restart.
    do_reset();
    start();
    for (int i = 0; i < c_N; i++) push_beat(i == 0);
    build_model(1'b0);
    begin
      int n = 0;
      while (popped < 10 && n < 200) begin
        cyc();
        n++;
      end
      check("mid_data_reached", 80'(popped >= 10), 80'd1);
    end
    #2;
    xike_rst_n = 1'b0;
    #1;
    check("async_m_tvalid", 80'(m_tvalid), 80'd0);
    check("async_busy", 80'(busy), 80'd0);
    do_reset();
    start();
    for (int i = 0; i < c_N; i++) push_beat(i == 0);
    build_model(1'b0);
    run(-1, 2000);
    end_checks();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
